// File: rtl/fp32_norm_pkg.sv
// fp32_norm_pkg: shared constants and the stage-1 bundle for the FP32 adder
// normalize/round stage (fp32_normalize_round, fp32_round_pack).
package fp32_norm_pkg;

  localparam logic [7:0] SHIFT_R1   = 8'h80;  // carry out: shift right by one
  localparam logic [7:0] SHIFT_ZERO = 8'h40;  // sum is exactly zero
  localparam int         MAX_LSHIFT = 47;
  localparam logic [7:0] EXP_MAX    = 8'hFF;
  localparam int         BIAS       = 127;

  // Normalized stage-1 result. e is signed and wide enough for exp-47 .. exp+2.
  // m holds the normalized sum with the hidden one at [47]; for inf/NaN inputs
  // it holds the raw mant_in so stage 2 can inspect the fraction.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic signed [9:0] e;
    logic [48:0]       m;
    logic              zero;
    logic              infnan;
    logic              err;
  } s1_t;

endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: combinational stage-2 of fp32_normalize_round.
// Rounds the normalized significand, applies exponent overflow/underflow and
// special-case handling, and packs an IEEE-754 single.
//   s1_i   in   stage-1 bundle (registered by the parent)
//   data_o out  packed FP32 result
//   ovf_o  out  saturated to infinity
//   unf_o  out  flushed to zero
//   err_o  out  illegal shift code seen
// Macro FP32_NORM_RNE_EN: defined -> round-to-nearest-even, undefined -> truncate.
module fp32_round_pack
  import fp32_norm_pkg::*;
(
  input  s1_t         s1_i,
  output logic [31:0] data_o,
  output logic        ovf_o,
  output logic        unf_o,
  output logic        err_o
);

  logic [23:0]       sig;
  logic signed [9:0] e;

`ifdef FP32_NORM_RNE_EN
  logic        inc;
  logic [24:0] sig_inc;

  always_comb begin
    // G = m[23], R = m[22], S = |m[21:0]; m[24] is the significand LSB (ties to even)
    inc     = s1_i.m[23] & (s1_i.m[22] | (|s1_i.m[21:0]) | s1_i.m[24]);
    sig_inc = {1'b0, s1_i.m[47:24]} + {24'h0, inc};
    if (sig_inc[24]) begin
      sig = 24'h800000;
      e   = s1_i.e + 10'sd1;
    end else begin
      sig = sig_inc[23:0];
      e   = s1_i.e;
    end
  end

  // Carry position and stage valid are not needed once the bundle is registered.
  logic unused_bits;
  assign unused_bits = s1_i.m[48] ^ s1_i.valid;
`else
  assign sig = s1_i.m[47:24];
  assign e   = s1_i.e;

  // Guard/sticky bits are simply discarded when truncating.
  logic unused_bits;
  assign unused_bits = ^{s1_i.m[48], s1_i.m[23:0], s1_i.valid};
`endif

  always_comb begin
    data_o = {s1_i.sign, e[7:0], sig[22:0]};
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    err_o  = s1_i.err;
    if (s1_i.zero) begin
      data_o = {s1_i.sign, 31'h0};
    end else if (s1_i.infnan) begin
      // Any nonzero input fraction collapses to the canonical quiet NaN.
      data_o = {s1_i.sign, EXP_MAX, (|s1_i.m[46:24]) ? 23'h400000 : 23'h0};
    end else if (e >= 10'sd255) begin
      data_o = {s1_i.sign, EXP_MAX, 23'h0};
      ovf_o  = 1'b1;
    end else if (e <= 10'sd0) begin
      data_o = {s1_i.sign, 31'h0};
      unf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/fp32_normalize_round.sv
// fp32_normalize_round: post-encoder stage of the FP32 adder. Normalizes the
// raw 49-bit sum by the leading-one shift code, rounds, handles exponent
// overflow/underflow and emits a packed FP32. Two-stage pipeline, 2-clk latency,
// no backpressure.
//   clk, rst    clock, asynchronous active-high reset
//   valid_in    input bundle valid
//   shift_code  8'h80 = right 1, 0..47 = left n, 8'h40 = zero sum
//   mant_in     raw mantissa sum [48]=carry [47]=hidden [46:24]=frac [23:0]=GRS
//   exp_in      biased exponent of the larger operand
//   sign_in     result sign
//   valid_out   out_data valid
//   out_data    packed FP32 result (holds while valid_out = 0)
//   ovf/unf/code_err  flags qualified by valid_out
// Macro FP32_NORM_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fp32_normalize_round
  import fp32_norm_pkg::*;
#(
  parameter int MANT_W  = 49,
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [SHIFT_W-1:0] shift_code,
  input  logic [MANT_W-1:0]  mant_in,
  input  logic [EXP_W-1:0]   exp_in,
  input  logic               sign_in,
  output logic               valid_out,
  output logic [31:0]        out_data,
  output logic               ovf,
  output logic               unf,
  output logic               code_err
);

  s1_t s1_d, s1_q;

  // Stage 1: normalize
  always_comb begin
    s1_d       = '0;
    s1_d.valid = valid_in;
    s1_d.sign  = sign_in;
    if (shift_code == SHIFT_R1) begin
      s1_d.m    = {1'b0, mant_in[48:1]};
      s1_d.m[0] = mant_in[1] | mant_in[0];  // shifted-out bit folds into sticky
      s1_d.e    = {2'b00, exp_in} + 10'd1;
    end else if (shift_code <= 8'(MAX_LSHIFT)) begin
      s1_d.m = mant_in << shift_code;
      s1_d.e = {2'b00, exp_in} - {2'b00, shift_code};
    end else if (shift_code == SHIFT_ZERO) begin
      s1_d.zero = 1'b1;
    end else begin
      s1_d.zero = 1'b1;
      s1_d.err  = 1'b1;
    end
    if (exp_in == EXP_MAX) begin
      s1_d.infnan = 1'b1;
      s1_d.m      = mant_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.valid <= valid_in;
      if (valid_in) s1_q <= s1_d;
    end
  end

  // Stage 2: round / exceptions / pack
  logic [31:0] data_d;
  logic        ovf_d, unf_d, err_d;

  fp32_round_pack u_round_pack (
    .s1_i   (s1_q),
    .data_o (data_d),
    .ovf_o  (ovf_d),
    .unf_o  (unf_d),
    .err_o  (err_d)
  );

  logic        valid_q;
  logic [31:0] data_q;
  logic        ovf_q, unf_q, err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        data_q <= data_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        err_q  <= err_d;
      end
    end
  end

  assign valid_out = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign code_err  = err_q;

endmodule

// File: tb/tb_fp32_normalize_round.sv
module tb_fp32_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [7:0]  shift_code;
  logic [48:0] mant_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        valid_out;
  logic [31:0] out_data;
  logic        ovf, unf, code_err;

  always #5 clk = ~clk;

  fp32_normalize_round dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .shift_code (shift_code),
    .mant_in    (mant_in),
    .exp_in     (exp_in),
    .sign_in    (sign_in),
    .valid_out  (valid_out),
    .out_data   (out_data),
    .ovf        (ovf),
    .unf        (unf),
    .code_err   (code_err)
  );

`ifdef FP32_NORM_RNE_EN
  localparam logic [31:0] TIE_EXP    = 32'h40000000;
  localparam logic [31:0] GR_EXP     = 32'h3F800001;
  localparam logic [31:0] RCARRY_EXP = 32'h7F800000;
  localparam logic        RCARRY_OVF = 1'b1;
  localparam logic [31:0] STKY_EXP   = 32'h40000001;
`else
  localparam logic [31:0] TIE_EXP    = 32'h3FFFFFFF;
  localparam logic [31:0] GR_EXP     = 32'h3F800000;
  localparam logic [31:0] RCARRY_EXP = 32'h7F7FFFFF;
  localparam logic        RCARRY_OVF = 1'b0;
  localparam logic [31:0] STKY_EXP   = 32'h40000000;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        o, u, e;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_d = '0;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every valid_out pops the oldest expectation
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {34'h0, valid_out}, 35'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {out_data, ovf, unf, code_err}, e);
        last_d = e.d;
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [48:0] m, input logic [7:0] x,
                      input logic s, input logic [31:0] d, input logic o, input logic u,
                      input logic e);
    exp_t ev;
    @(negedge clk);
    valid_in   = 1'b1;
    shift_code = c;
    mant_in    = m;
    exp_in     = x;
    sign_in    = s;
    ev = '{d: d, o: o, u: u, e: e};
    sb.push_back(ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; shift_code = '0; mant_in = '0; exp_in = '0; sign_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {valid_out, out_data, ovf, unf, code_err}, 36'h0);
    rst = 1'b0;

    // 1.0 + 1.0, with explicit 2-cycle latency check
    send(8'h80, 49'h1_0000_0000_0000, 8'd127, 1'b0, 32'h40000000, 0, 0, 0);
    @(negedge clk); valid_in = 1'b0;
    chk("latency_1", {34'h0, valid_out}, 35'h0);
    @(negedge clk);
    chk("latency_2", {34'h0, valid_out}, 35'h1);

    // Directed vectors, back-to-back
    send(8'd1,  49'h0_4000_0000_0000, 8'd127, 1'b0, 32'h3F000000, 0, 0, 0);
    send(8'h40, 49'h0,                8'd127, 1'b1, 32'h80000000, 0, 0, 0);
    send(8'h41, 49'h0,                8'd127, 1'b0, 32'h00000000, 0, 0, 1);
    send(8'd0,  49'h0_FFFF_FF80_0000, 8'd127, 1'b0, TIE_EXP,      0, 0, 0);
    send(8'h80, 49'h1_0000_0000_0000, 8'd254, 1'b0, 32'h7F800000, 1, 0, 0);
    send(8'd10, 49'h0_0020_0000_0000, 8'd5,   1'b0, 32'h00000000, 0, 1, 0);
    send(8'd0,  49'h0_8000_00C0_0000, 8'd127, 1'b0, GR_EXP,       0, 0, 0);
    send(8'd0,  49'h0_8000_0000_0000, 8'd100, 1'b1, 32'hB2000000, 0, 0, 0);
    send(8'd0,  49'h0_8000_0100_0000, 8'hFF,  1'b0, 32'h7FC00000, 0, 0, 0);
    send(8'd0,  49'h0_8000_0000_0000, 8'hFF,  1'b1, 32'hFF800000, 0, 0, 0);
    send(8'd1,  49'h0_4000_0000_0000, 8'd1,   1'b0, 32'h00000000, 0, 1, 0);
    send(8'd0,  49'h0_8000_0000_0000, 8'd254, 1'b0, 32'h7F000000, 0, 0, 0);
    send(8'd48, 49'h0_8000_0000_0000, 8'd127, 1'b1, 32'h80000000, 0, 0, 1);
    send(8'd47, 49'h0_0000_0000_0001, 8'd200, 1'b0, 32'h4C800000, 0, 0, 0);
    send(8'd0,  49'h0_FFFF_FFC0_0000, 8'd254, 1'b0, RCARRY_EXP, RCARRY_OVF, 0, 0);
    send(8'h80, 49'h1_0000_0100_0001, 8'd127, 1'b0, STKY_EXP,     0, 0, 0);
    idle(4);

    // out_data holds its last value while valid_out is low
    chk("hold", {valid_out, out_data, 2'b00}, {1'b0, last_d, 2'b00});

    // Streaming with a reset pulse in the middle
    send(8'd1,  49'h0_4000_0000_0000, 8'd127, 1'b0, 32'h3F000000, 0, 0, 0);
    send(8'h80, 49'h1_0000_0000_0000, 8'd127, 1'b1, 32'hC0000000, 0, 0, 0);
    send(8'h41, 49'h0,                8'd127, 1'b0, 32'h00000000, 0, 0, 1);
    send(8'd0,  49'h0_8000_0000_0000, 8'd100, 1'b1, 32'hB2000000, 0, 0, 0);
    @(negedge clk); valid_in = 1'b0;
    #2 rst = 1'b1;
    sb.delete();
    #1 chk("mid_reset", {valid_out, out_data, ovf, unf, code_err}, 36'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {34'h0, valid_out}, 35'h0);
    end
    send(8'd0,  49'h0_FFFF_FF80_0000, 8'd127, 1'b0, TIE_EXP,      0, 0, 0);
    send(8'd10, 49'h0_0020_0000_0000, 8'd5,   1'b1, 32'h80000000, 0, 1, 0);
    send(8'h80, 49'h1_0000_0000_0000, 8'd254, 1'b1, 32'hFF800000, 1, 0, 0);
    send(8'd1,  49'h0_4000_0000_0000, 8'd127, 1'b0, 32'h3F000000, 0, 0, 0);
    idle(5);

    chk("drain", 35'(sb.size()), 35'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
